// File: rtl/dsram_mp.sv
// dsram_mp: multi-read-port distributed SRAM with byte-enabled write port and clear sweep.
// Define DSRAM_MP_WRITE_FORWARD_EN to bypass same-cycle user writes onto matching read ports.
module dsram_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int SIZE = 8192,
  parameter int RD_PORTS = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  output logic                           busy,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] SZ = (ADDR_WIDTH+1)'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic wr_ok;
  assign busy = (state == CLEAR);
  assign wr_ok = we && !busy && ({1'b0, wr_addr} < SZ);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
    end else if (state == CLEAR) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
      if (ptr == LAST) state <= IDLE;
    end else if (clear) begin
      state <= CLEAR;
    end
  always_ff @(posedge clk)
    if (busy)
      mem[ptr[IW-1:0]] <= INIT_VALUE;
    else if (wr_ok)
      for (int i = 0; i < NB; i++)
        if (wr_be[i]) mem[wr_addr[IW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] rd;
    assign a = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd;
    always_comb begin
      rd = ({1'b0, a} < SZ) ? mem[a[IW-1:0]] : '0;
`ifdef DSRAM_MP_WRITE_FORWARD_EN
      for (int i = 0; i < NB; i++)
        if (wr_ok && wr_addr == a && wr_be[i]) rd[8*i +: 8] = wr_data[8*i +: 8];
`endif
    end
  end
endmodule

// File: tb/tb_dsram_mp.sv
// tb_dsram_mp: scoreboard bench for dsram_mp with an array-based reference model.
module tb_dsram_mp;
  localparam int DW = 16, AW = 5, SZ = 16, RP = 2;
  localparam logic [DW-1:0] INIT = 16'hA5A5;
  logic clk = 0, rst_n = 0, clear = 0, we = 0;
  logic busy;
  logic [RP*AW-1:0] rd_addr = '0;
  logic [RP*DW-1:0] rd_data;
  logic [1:0] wr_be = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  always #5 clk = ~clk;
  dsram_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .RD_PORTS(RP), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
    .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data));
  typedef struct {int k; logic [DW-1:0] v; int id;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [DW-1:0] mem_m [SZ];
  bit known [SZ];
  int busy_left = SZ;
  logic [DW-1:0] act;
  task automatic push(int k, logic [DW-1:0] v, int id);
    exp_t x;
    x.k = k; x.v = v; x.id = id;
    q.push_back(x);
  endtask
  function automatic bit wq();
    return rst_n && busy_left == 0 && we && int'(wr_addr) < SZ;
  endfunction
  function automatic logic [DW-1:0] model_rd(int a);
    logic [DW-1:0] r;
    r = mem_m[a];
`ifdef DSRAM_MP_WRITE_FORWARD_EN
    for (int i = 0; i < 2; i++)
      if (wq() && a == int'(wr_addr) && wr_be[i]) r[8*i +: 8] = wr_data[8*i +: 8];
`endif
    return r;
  endfunction
  task automatic set_rst(logic v);
    rst_n = v;
    if (!v) busy_left = SZ;
  endtask
  task automatic cyc(int id);
    push(2, 16'(busy_left > 0), id);
    for (int p = 0; p < RP; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      if (a >= SZ) push(p, '0, id);
      else if (known[a]) push(p, model_rd(a), id);
    end
    @(posedge clk);
    if (rst_n) begin
      if (busy_left > 0) begin
        mem_m[SZ - busy_left] = INIT;
        known[SZ - busy_left] = 1;
        busy_left--;
      end else begin
        if (wq())
          for (int i = 0; i < 2; i++) if (wr_be[i]) mem_m[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
        if (clear) busy_left = SZ;
      end
    end
    #1;
  endtask
  task automatic wr(logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] be);
    we = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      e = q.pop_front();
      act = (e.k == 2) ? {15'b0, busy} : rd_data[e.k*DW +: DW];
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL id=%0d kind=%0d got=%h expected=%h t=%0t", e.id, e.k, act, e.v, $time);
      end
    end
  initial begin
    @(posedge clk); #1;
    repeat (3) cyc(0);
    set_rst(1);
    repeat (SZ) cyc(1);
    for (int a = 0; a < SZ; a++) begin
      rd_addr = {AW'(SZ - 1 - a), AW'(a)};
      push(0, INIT, 10); push(1, INIT, 10);
      cyc(11);
    end
    rd_addr = {AW'(0), AW'(3)};
    wr(3, 16'h1234, 2'b11); cyc(20); we = 0; push(0, 16'h1234, 21); cyc(21);
    wr(3, 16'hFFFF, 2'b01); cyc(22); we = 0; push(0, 16'h12FF, 23); cyc(23);
    wr(3, 16'h0000, 2'b00); cyc(24); we = 0; push(0, 16'h12FF, 25); cyc(25);
    wr(3, 16'h0003, 2'b11); cyc(30);
    wr(5, 16'h0005, 2'b11); cyc(31); we = 0;
    rd_addr = {AW'(5), AW'(3)}; push(0, 16'h0003, 32); push(1, 16'h0005, 32); cyc(32);
    rd_addr = {AW'(5), AW'(5)}; push(0, 16'h0005, 33); push(1, 16'h0005, 33); cyc(33);
    rd_addr = {AW'(2), AW'(2)};
    clear = 1; cyc(40); clear = 0;
    wr(2, 16'hBEEF, 2'b11); repeat (5) cyc(41); we = 0;
    repeat (2) cyc(42);
    clear = 1; cyc(43); clear = 0;
    repeat (8) cyc(44);
    push(2, 0, 45); push(0, INIT, 45); cyc(45);
    clear = 1; cyc(50); clear = 0;
    repeat (7) cyc(51);
    set_rst(0); repeat (2) cyc(52);
    set_rst(1); repeat (SZ) cyc(53);
    push(2, 0, 54); cyc(54);
    rd_addr = {AW'(20), AW'(20)};
    wr(20, 16'h1357, 2'b11); cyc(55); we = 0;
    push(0, 0, 56); push(1, 0, 56); cyc(56);
    wr(3, 16'h1111, 2'b11); cyc(60);
    rd_addr = {AW'(3), AW'(3)};
`ifdef DSRAM_MP_WRITE_FORWARD_EN
    wr(3, 16'h2222, 2'b10); push(1, 16'h2211, 61); cyc(61);
`else
    wr(3, 16'h2222, 2'b10); push(1, 16'h1111, 61); cyc(61);
`endif
    we = 0; push(1, 16'h2211, 62); cyc(62);
    repeat (500) begin
      clear = ($urandom_range(0, 59) == 0);
      we = 1'($urandom_range(0, 1));
      wr_be = 2'($urandom);
      wr_addr = AW'($urandom_range(0, 20));
      wr_data = DW'($urandom);
      rd_addr = {AW'($urandom_range(0, 20)), AW'($urandom_range(0, 20))};
      if ($urandom_range(0, 2) == 0) rd_addr[AW +: AW] = wr_addr;
      if ($urandom_range(0, 3) == 0) rd_addr[0 +: AW] = wr_addr;
      cyc(100);
    end
    we = 0; clear = 0;
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
